// File: rtl/fsm_multi_state.sv
// Parametrised request-driven mode selector with minimum dwell, hold, change strobe
// and an optional idle timeout enabled by FSM_MULTI_STATE_TIMEOUT_EN.
module fsm_multi_state #(
  parameter int STATES    = 3,
  parameter int MIN_DWELL = 0,
  parameter int TIMEOUT   = 16,
  localparam int SW = ($clog2(STATES) < 1) ? 1 : $clog2(STATES),
  localparam int OW = $clog2(STATES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STATES-1:0] req,
  input  logic              hold,
  output logic [SW-1:0]     st,
  output logic [OW-1:0]     dout,
  output logic              changed,
  output logic              timeout
);

  localparam logic [7:0] DWELL_MAX = 8'(MIN_DWELL);

  logic [SW-1:0] st_q, st_d;
  logic [7:0]    dwell_q, dwell_d;
  logic          changed_q, changed_d;
  logic          has_req, multi_req, dwell_ok, fire;
  logic [SW-1:0] idx_or, target;
  logic [SW-1:0] idx_term [STATES];

  // Each request bit contributes its own index; OR-ing is exact for one-hot vectors.
  genvar gi;
  generate
    for (gi = 0; gi < STATES; gi++) begin : g_idx
      assign idx_term[gi] = req[gi] ? SW'(gi) : '0;
    end
  endgenerate

  always_comb begin
    idx_or = '0;
    for (int i = 0; i < STATES; i++) begin
      idx_or = idx_or | idx_term[i];
    end
  end

  assign has_req   = |req;
  assign multi_req = |(req & (req - STATES'(1)));
  assign target    = multi_req ? SW'(STATES - 1) : idx_or;

  // The cycle ending at this edge counts as served, so a state lasts at least MIN_DWELL cycles.
  generate
    if (MIN_DWELL == 0) begin : g_no_dwell
      assign dwell_ok = 1'b1;
    end else begin : g_dwell
      assign dwell_ok = ({1'b0, dwell_q} + 9'd1) >= 9'(MIN_DWELL);
    end
  endgenerate

  always_comb begin
    st_d = st_q;
    if (!hold) begin
      if (fire) begin
        st_d = '0;
      end else if (has_req && (target != st_q) && dwell_ok) begin
        st_d = target;
      end
    end
    changed_d = (st_d != st_q);
    if (changed_d) begin
      dwell_d = '0;
    end else if (dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + 8'd1;
    end else begin
      dwell_d = dwell_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '0;
      dwell_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      dwell_q   <= dwell_d;
      changed_q <= changed_d;
    end
  end

`ifdef FSM_MULTI_STATE_TIMEOUT_EN
  localparam logic [15:0] TO16 = 16'(TIMEOUT);

  logic [15:0] idle_q, idle_d, idle_inc;
  logic        idle_now;
  logic        timeout_q;

  // Saturating count lets a forced return wait out a hold and fire once it drops.
  always_comb begin
    idle_now = (st_q != '0) && !has_req;
    idle_inc = (idle_q == TO16) ? idle_q : idle_q + 16'd1;
    fire     = idle_now && !hold && (idle_inc == TO16);
  end

  always_comb begin
    idle_d = (changed_d || !idle_now) ? '0 : idle_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= fire;
    end
  end

  assign timeout = timeout_q;
`else
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

  assign st      = st_q;
  assign dout    = OW'(st_q) + OW'(1);
  assign changed = changed_q;

endmodule

// File: tb/tb_fsm_multi_state.sv
// Directed bench for fsm_multi_state: a 3-state/no-dwell and a 5-state/dwell-4 instance
// checked each cycle against a cycle-counting model, plus literal expectations.
module tb_fsm_multi_state;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chk_en = 1'b0;
  logic [2:0] req3;
  logic       hold3;
  logic [1:0] st3, dout3;
  logic       chg3, to3;
  logic [4:0] req5;
  logic       hold5;
  logic [2:0] st5, dout5;
  logic       chg5, to5;
  int         n_vec  = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  fsm_multi_state #(.STATES(3), .MIN_DWELL(0), .TIMEOUT(6)) u3 (
    .clk(clk), .rst(rst), .req(req3), .hold(hold3),
    .st(st3), .dout(dout3), .changed(chg3), .timeout(to3)
  );

  fsm_multi_state #(.STATES(5), .MIN_DWELL(4), .TIMEOUT(6)) u5 (
    .clk(clk), .rst(rst), .req(req5), .hold(hold5),
    .st(st5), .dout(dout5), .changed(chg5), .timeout(to5)
  );

  // in_cyc: cycles completed in the current state; idle: consecutive idle cycles in a nonzero state.
  typedef struct {
    int st;
    int in_cyc;
    int idle;
    bit chg;
    bit to;
  } mdl_t;

  mdl_t m3, m5;

  function automatic mdl_t step(mdl_t m, logic [15:0] r, bit h, bit rs, int n, int d);
    mdl_t o;
    int   ones;
    int   tgt;
    int   nxt;
    bit   forced;
    o = m;
    ones = 0;
    tgt = 0;
    forced = 1'b0;
    if (rs) begin
      o.st = 0; o.in_cyc = 0; o.idle = 0; o.chg = 1'b0; o.to = 1'b0;
      return o;
    end
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        ones++;
        tgt = i;
      end
    end
    if (ones > 1) tgt = n - 1;
    o.in_cyc = m.in_cyc + 1;
    o.idle   = (m.st != 0 && ones == 0) ? m.idle + 1 : 0;
    nxt  = m.st;
    o.to = 1'b0;
    if (!h) begin
`ifdef FSM_MULTI_STATE_TIMEOUT_EN
      forced = (o.idle >= 6);
`endif
      if (forced) begin
        nxt  = 0;
        o.to = 1'b1;
      end else if (ones > 0 && tgt != m.st && o.in_cyc >= d) begin
        nxt = tgt;
      end
    end
    o.chg = (nxt != m.st);
    if (o.chg) begin
      o.in_cyc = 0;
      o.idle   = 0;
    end
    o.st = nxt;
    return o;
  endfunction

  always @(posedge clk) begin
    m3 <= step(m3, 16'(req3), hold3, rst, 3, 0);
    m5 <= step(m5, 16'(req5), hold5, rst, 5, 4);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("u3.st", 32'(st3), 32'(m3.st));
      cmp("u3.dout", 32'(dout3), 32'(m3.st + 1));
      cmp("u3.changed", 32'(chg3), 32'(m3.chg));
      cmp("u3.timeout", 32'(to3), 32'(m3.to));
      cmp("u5.st", 32'(st5), 32'(m5.st));
      cmp("u5.dout", 32'(dout5), 32'(m5.st + 1));
      cmp("u5.changed", 32'(chg5), 32'(m5.chg));
      cmp("u5.timeout", 32'(to5), 32'(m5.to));
    end
  end

  task automatic tick(input logic [2:0] r3, input logic h3, input logic [4:0] r5, input logic h5);
    req3 = r3; hold3 = h3; req5 = r5; hold5 = h5;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t rst=%b req3=%b hold3=%b st3=%0d | req5=%b hold5=%b st5=%0d",
             $time, rst, r3, h3, st3, r5, h5, st5);
  endtask

  initial begin
    rst = 1'b1;
    tick(3'b000, 1'b0, 5'b00000, 1'b0);
    tick(3'b000, 1'b0, 5'b00000, 1'b0);
    chk_en = 1'b1;
    cmp("rst st3", 32'(st3), 0);
    cmp("rst dout3", 32'(dout3), 1);
    cmp("rst chg3", 32'(chg3), 0);
    cmp("rst to3", 32'(to3), 0);
    cmp("rst st5", 32'(st5), 0);
    rst = 1'b0;

    // Basic decode and self-request
    tick(3'b010, 1'b0, 5'b00000, 1'b0);
    cmp("dec st3=1", 32'(st3), 1);
    cmp("dec dout3=2", 32'(dout3), 2);
    cmp("dec chg3", 32'(chg3), 1);
    repeat (5) tick(3'b010, 1'b0, 5'b00000, 1'b0);
    cmp("self st3", 32'(st3), 1);
    cmp("self chg3", 32'(chg3), 0);
    tick(3'b011, 1'b0, 5'b00000, 1'b0);
    cmp("multi st3=2", 32'(st3), 2);
    cmp("multi dout3=3", 32'(dout3), 3);
    tick(3'b001, 1'b0, 5'b00000, 1'b0);
    cmp("b2b st3=0", 32'(st3), 0);
    cmp("b2b dout3=1", 32'(dout3), 1);
    cmp("b2b chg3", 32'(chg3), 1);
    tick(3'b111, 1'b0, 5'b00000, 1'b0);
    cmp("all st3=2", 32'(st3), 2);
    tick(3'b001, 1'b0, 5'b00000, 1'b0);
    repeat (10) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    cmp("noreq st3", 32'(st3), 0);

    // Idle timeout on u3
    tick(3'b100, 1'b0, 5'b00000, 1'b0);
    repeat (5) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    cmp("idle5 st3", 32'(st3), 2);
    cmp("idle5 to3", 32'(to3), 0);
    tick(3'b000, 1'b0, 5'b00000, 1'b0);
`ifdef FSM_MULTI_STATE_TIMEOUT_EN
    cmp("to st3", 32'(st3), 0);
    cmp("to to3", 32'(to3), 1);
    cmp("to chg3", 32'(chg3), 1);
`else
    cmp("noto st3", 32'(st3), 2);
    cmp("noto to3", 32'(to3), 0);
`endif
    tick(3'b100, 1'b0, 5'b00000, 1'b0);
    cmp("re st3", 32'(st3), 2);
    repeat (3) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    tick(3'b100, 1'b0, 5'b00000, 1'b0);
    repeat (5) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    cmp("restart st3", 32'(st3), 2);
    tick(3'b000, 1'b0, 5'b00000, 1'b0);
`ifdef FSM_MULTI_STATE_TIMEOUT_EN
    cmp("restart to st3", 32'(st3), 0);
    cmp("restart to3", 32'(to3), 1);
`else
    cmp("restart noto st3", 32'(st3), 2);
`endif
    tick(3'b100, 1'b0, 5'b00000, 1'b0);
    repeat (8) tick(3'b000, 1'b1, 5'b00000, 1'b0);
    cmp("hold idle st3", 32'(st3), 2);
    cmp("hold idle to3", 32'(to3), 0);
    tick(3'b000, 1'b0, 5'b00000, 1'b0);
`ifdef FSM_MULTI_STATE_TIMEOUT_EN
    cmp("unhold to st3", 32'(st3), 0);
    cmp("unhold to3", 32'(to3), 1);
`else
    cmp("unhold st3", 32'(st3), 2);
`endif
    tick(3'b001, 1'b0, 5'b00000, 1'b0);
    cmp("home st3", 32'(st3), 0);

    // Dwell guard on u5
    tick(3'b000, 1'b0, 5'b00100, 1'b0);
    cmp("dw enter st5", 32'(st5), 2);
    cmp("dw enter chg5", 32'(chg5), 1);
    repeat (3) tick(3'b000, 1'b0, 5'b01000, 1'b0);
    cmp("dw early st5", 32'(st5), 2);
    repeat (2) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    cmp("dw drop st5", 32'(st5), 2);
    tick(3'b000, 1'b0, 5'b00001, 1'b0);
    cmp("dw home st5", 32'(st5), 0);
    repeat (4) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    tick(3'b000, 1'b0, 5'b00100, 1'b0);
    cmp("dw enter2 st5", 32'(st5), 2);
    repeat (3) tick(3'b000, 1'b0, 5'b01000, 1'b0);
    cmp("dw 3cyc st5", 32'(st5), 2);
    tick(3'b000, 1'b0, 5'b01000, 1'b0);
    cmp("dw 4cyc st5", 32'(st5), 3);
    cmp("dw 4cyc dout5", 32'(dout5), 4);
    cmp("dw 4cyc chg5", 32'(chg5), 1);

    // Hold on u5
    repeat (8) tick(3'b000, 1'b0, 5'b00001, 1'b1);
    cmp("hold st5", 32'(st5), 3);
    cmp("hold chg5", 32'(chg5), 0);
    tick(3'b000, 1'b0, 5'b00001, 1'b0);
    cmp("release st5", 32'(st5), 0);
    cmp("release chg5", 32'(chg5), 1);
    repeat (4) tick(3'b000, 1'b0, 5'b00000, 1'b0);
    tick(3'b000, 1'b0, 5'b00110, 1'b0);
    cmp("multi st5=4", 32'(st5), 4);
    cmp("multi dout5=5", 32'(dout5), 5);

    // Reset mid-dwell (u5) and mid-idle (u3)
    tick(3'b100, 1'b0, 5'b00010, 1'b0);
    repeat (2) tick(3'b000, 1'b0, 5'b00010, 1'b0);
    cmp("pre-rst st3", 32'(st3), 2);
    cmp("pre-rst st5", 32'(st5), 4);
    rst = 1'b1;
    tick(3'b000, 1'b0, 5'b00010, 1'b0);
    cmp("midrst st3", 32'(st3), 0);
    cmp("midrst chg3", 32'(chg3), 0);
    cmp("midrst to3", 32'(to3), 0);
    cmp("midrst st5", 32'(st5), 0);
    cmp("midrst chg5", 32'(chg5), 0);
    rst = 1'b0;
    tick(3'b010, 1'b0, 5'b00100, 1'b0);
    cmp("post-rst st3", 32'(st3), 1);
    cmp("post-rst chg3", 32'(chg3), 1);
    cmp("post-rst st5", 32'(st5), 0);
    tick(3'b000, 1'b0, 5'b00000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fsm_multi_state.md
# fsm_multi_state

Parametrised successor of the team's small Moore FSM example. Holds one of `STATES` states, selected by a request vector, and adds a minimum-dwell guard, a hold input, a state-change strobe and an optional idle timeout. Used as the generic mode selector in statement and FSM examples and as a control core for small datapaths. With `STATES=3`, `MIN_DWELL=0`, `hold=0` and the timeout compiled out, behaviour matches the original 3-state example exactly.

## Interface

Parameters:
- `STATES`, 3: number of states; legal range 2..16.
- `MIN_DWELL`, 0: cycles a state must be held before a request may leave it; legal range 0..255.
- `TIMEOUT`, 16: idle cycles before the forced return to state 0; legal range 1..65535. Used only with the macro.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `req`, input, `STATES`: request vector, sampled every cycle.
- `hold`, input, 1: when 1, blocks all state transitions.
- `st`, output, SW = max(1, ceil(log2(STATES))): current state, registered.
- `dout`, output, OW = ceil(log2(STATES+1)): state code, combinational decode of `st`.
- `changed`, output, 1: one-cycle strobe, high in the first cycle of a new `st`.
- `timeout`, output, 1: one-cycle strobe, high in the first cycle after a forced timeout return.

## Operation

- Target decode, combinational from `req`:
  - popcount(req) = 0: no request.
  - popcount(req) = 1: target = index of the set bit.
  - popcount(req) ≥ 2: target = `STATES-1`.
- Dwell counter `dwell`, 8 bits:
  - Cleared on every state change and on reset.
  - Increments each cycle; saturates at `MIN_DWELL`.
- Next-state rule, evaluated in priority order:
  1. `rst` → `st` = 0.
  2. `hold` = 1 → stay.
  3. Timeout condition (macro only) → `st` = 0.
  4. Request present, and target ≠ `st`, and `dwell` ≥ `MIN_DWELL` → `st` = target.
  5. Otherwise → stay.
- A request whose target equals `st` is not a transition. It does not clear `dwell` and does not pulse `changed`.
- `dout` = `st` + 1, zero-extended to OW. For `STATES=3`: codes 1, 2, 3.
- `changed` is registered: 1 in the cycle after any edge where `st` changed value, including changes caused by a timeout.
- Reset mid-dwell or mid-idle:
  - Clears all counters on the same edge.
  - Does not pulse `changed` or `timeout`.

## Timing

- Reset values: `st`=0, `dout`=1, `changed`=0, `timeout`=0, `dwell`=0, idle counter 0.
- Latency: `req` sampled at edge N → `st` and `dout` show the new value after edge N; `changed` is high in the cycle following edge N.
- `hold` and `req` are level inputs with no handshake. A request that is present only while blocked (by `hold` or by the dwell guard) is lost; no queuing.
- Dwell guard with `MIN_DWELL` = D: at least D full cycles elapse in a state before a request can move out of it.
- Back-to-back transitions on consecutive edges are legal when `MIN_DWELL` = 0.

## Configuration

- Macro: `FSM_MULTI_STATE_TIMEOUT_EN`.
- Defined:
  - A 16-bit idle counter increments each cycle while `st` ≠ 0 and `req` = 0.
  - The counter clears on any nonzero `req`, on any state change, and while `st` = 0.
  - When the counter reaches `TIMEOUT` and `hold` = 0, `st` → 0 on that edge. The dwell guard is ignored for this transition.
  - `timeout` pulses with `changed` in the following cycle.
  - With `hold` = 1, the counter saturates at `TIMEOUT` and the forced return fires on the first edge after `hold` falls.
- Not defined:
  - Idle counter removed.
  - `timeout` tied to 0.
  - Idle states persist indefinitely.

## Test plan

- Reset and default decode (`STATES`=3, `MIN_DWELL`=0): after `rst`, `st`=0 and `dout`=1. Then:
  - `req`=2'b10 → `st`=1, `dout`=2, one `changed` pulse.
  - `req`=2'b11 → `st`=2, `dout`=3.
  - `req`=2'b01 → `st`=0.
  - `req`=0 for 10 cycles → `st` unchanged.
- Self-request: in `st`=1, drive `req`=2'b10 for 5 cycles → no `changed` pulse, `dwell` not cleared.
- Dwell guard (`STATES`=5, `MIN_DWELL`=4): move to `st`=2, then hold `req`=5'b01000 continuously → `st`=3 exactly 4 cycles after entering state 2. Any earlier drop of `req` leaves `st`=2.
- Hold: `hold`=1 with `req`=5'b00001 for 8 cycles → `st` unchanged. Release `hold` → `st`=0 on the next edge.
- Timeout (macro defined, `TIMEOUT`=6): enter `st`=2, then `req`=0 → `st`=0 after the 6th idle cycle, with `timeout` and `changed` high together for one cycle. A single `req` pulse at idle cycle 4 restarts the count.
- Reset mid-operation: assert `rst` during a dwell wait and during an idle count → `st`=0, no strobes. Normal decode resumes on the first cycle after `rst` falls.
